// File: rtl/b13_serial_rx_if.sv
// ----------------------------------------------------------------------------
// b13_serial_rx_if
//
// Bundles the serial line, the byte handshake and the status flags of the
// b13 serial receiver.
//
// Handshake: rx_valid high means rx_data holds an unconsumed byte. The
// consumer raises rx_ack to take the byte. The byte is consumed on the rising
// clock edge where rx_valid and rx_ack are both high. An rx_ack seen while
// rx_valid is low has no effect. If a new byte is loaded on the same edge as
// an ack, the new byte stays valid.
//
// Signals:
//   line_in    serial line, idles high (driven by the transmitter side)
//   rx_ack     consumer accepts the current byte
//   rx_data    last received byte
//   rx_valid   rx_data holds an unconsumed byte
//   frame_err  one-cycle pulse when a frame is rejected
//   overrun    sticky: a good byte was dropped while rx_valid was high
//   busy       receiver FSM is not idle
//   fsm_state  raw receiver FSM state (0 idle, 1 data, 2 stop) for debug
//
// Modports:
//   master  receiver side (drives the byte, flags and debug state)
//   slave   line driver / consumer side
// ----------------------------------------------------------------------------
interface b13_serial_rx_if;
    logic       line_in;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
    logic [1:0] fsm_state;

    modport master (
        input  line_in,
        input  rx_ack,
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        output busy,
        output fsm_state
    );

    modport slave (
        output line_in,
        output rx_ack,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  busy,
        input  fsm_state
    );
endinterface

// File: rtl/b13_serial_rx.sv
// ----------------------------------------------------------------------------
// b13_serial_rx
//
// Decodes the strobed serial frame of the b13 transmitter into bytes. A frame
// is a start strobe (line low for one cycle), eight data strobes MSB first and
// a stop strobe, spaced BIT_PERIOD cycles apart. On a data strobe a low line
// means 0 and a high line means 1. The stop strobe must read high.
//
// Parameters:
//   BIT_PERIOD  cycles between strobes (2 .. 2**CNT_W-1)
//   CNT_W       width of the bit-period counter
//
// Ports:
//   clock  sole clock, rising edge
//   reset  asynchronous, active-high
//   bus    b13_serial_rx_if.master (line_in, rx_ack, rx_data, rx_valid,
//          frame_err, overrun, busy, fsm_state)
//
// Build option:
//   B13_SERIAL_RX_GLITCH_CHECK_EN  when defined, a low on any non-strobe cycle
//   during DATA or STOP aborts the frame with a frame_err pulse.
// ----------------------------------------------------------------------------
module b13_serial_rx #(
    parameter int BIT_PERIOD = 106,
    parameter int CNT_W      = 10
) (
    input  logic           clock,
    input  logic           reset,
    b13_serial_rx_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] PERIOD  = CNT_W'(BIT_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef B13_SERIAL_RX_GLITCH_CHECK_EN
    localparam bit GLITCH_CHECK = 1'b1;
`else
    localparam bit GLITCH_CHECK = 1'b0;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shift;

    logic strobe;
    logic glitch;
    logic ack_hit;

    // The counter counts the cycles since the last strobe; it equals PERIOD
    // exactly on the next strobe cycle.
    assign strobe  = (cnt == PERIOD);
    // A low on a cycle that is not a strobe can only be line noise.
    assign glitch  = GLITCH_CHECK && (state != IDLE) && !strobe && !bus.line_in;
    assign ack_hit = bus.rx_ack && bus.rx_valid;

    assign bus.fsm_state = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            shift         <= '0;
            bus.rx_data   <= '0;
            bus.rx_valid  <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.frame_err <= 1'b0;

            // Consumption first; a load later in this block overrides the
            // rx_valid clear.
            if (ack_hit) begin
                bus.rx_valid <= 1'b0;
                bus.overrun  <= 1'b0;
            end

            if (glitch) begin
                state         <= IDLE;
                cnt           <= '0;
                idx           <= '0;
                bus.frame_err <= 1'b1;
                bus.busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!bus.line_in) begin
                            state    <= DATA;
                            cnt      <= CNT_ONE;
                            idx      <= '0;
                            bus.busy <= 1'b1;
                        end
                    end
                    DATA: begin
                        if (strobe) begin
                            shift[3'd7 - idx] <= bus.line_in;
                            cnt               <= CNT_ONE;
                            idx               <= idx + 3'd1;
                            if (idx == 3'd7) begin
                                state <= STOP;
                            end
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    STOP: begin
                        if (strobe) begin
                            state    <= IDLE;
                            cnt      <= '0;
                            bus.busy <= 1'b0;
                            if (bus.line_in) begin
                                if (!bus.rx_valid || bus.rx_ack) begin
                                    bus.rx_data  <= shift;
                                    bus.rx_valid <= 1'b1;
                                end else begin
                                    bus.overrun <= 1'b1;
                                end
                            end else begin
                                bus.frame_err <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        cnt      <= '0;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
